// File: rtl/fp_ftoi_param.sv
// fp_ftoi_param: pipelined IEEE-754 to integer converter, six-cycle latency, one operand per cycle.
// Define FP_FTOI_DIRECTED_RND_EN to enable the toward +inf / toward -inf rounding modes.
module fp_ftoi_param #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int INT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [EXP_W+MAN_W:0] din,
   input  logic [1:0]           rnd_mode,
   input  logic                 is_unsigned,
   output logic [INT_W-1:0]     dout,
   output logic                 rdy,
   output logic                 overflow,
   output logic                 invalid_op,
   output logic                 inexact
);

   localparam int EW  = (EXP_W + 2 > 9) ? EXP_W + 2 : 9;
   localparam int SW  = $clog2(INT_W + 1);
   localparam int WIN = INT_W + MAN_W + 2;
   localparam logic signed [EW-1:0] BIAS_S = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] INTW_S = EW'(INT_W);
   localparam logic signed [EW-1:0] NEG1_S = EW'(-1);
   localparam logic [SW-1:0]        RSH0   = SW'(INT_W - 1);
   localparam logic [INT_W-1:0]     SMAX   = {1'b0, {(INT_W-1){1'b1}}};
   localparam logic [INT_W-1:0]     SMIN   = {1'b1, {(INT_W-1){1'b0}}};

   typedef struct packed {
      logic       sign;
      logic [1:0] mode;
      logic       uns;
      logic       nan;
      logic       inf;
      logic       zer;
      logic       big;
      logic       tiny;
      logic       mnz;
   } ctl_t;

   function automatic logic [WIN-1:0] shr_grp(input logic [WIN-1:0] x,
                                              input logic [SW-1:0]  amt,
                                              input int             grp);
      logic [WIN-1:0] y;
      y = x;
      for (int k = 0; k < SW; k++)
         if (((k % 3) == grp) && amt[k]) y = y >> (1 << k);
      return y;
   endfunction

`ifdef FP_FTOI_DIRECTED_RND_EN
   function automatic logic rnd_inc(input logic [1:0] mode, input logic sign,
                                    input logic g, input logic s, input logic lsb);
      logic r;
      r = 1'b0;
      case (mode)
         2'b01:   r = g & (s | lsb);
         2'b10:   r = (g | s) & ~sign;
         2'b11:   r = (g | s) & sign;
         default: r = 1'b0;
      endcase
      return r;
   endfunction
`else
   function automatic logic rnd_inc(input logic [1:0] mode,
                                    input logic g, input logic s, input logic lsb);
      return (mode == 2'b01) & g & (s | lsb);
   endfunction
`endif

   function automatic logic [INT_W-1:0] sat_val(input logic sign, input logic uns);
      if (uns) return sign ? {INT_W{1'b0}} : {INT_W{1'b1}};
      return sign ? SMIN : SMAX;
   endfunction

   logic                 vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q, vld_p5_q;
   ctl_t                 ctl_c, ctl_p1_q, ctl_p2_q, ctl_p3_q, ctl_p4_q;
   logic [WIN-1:0]       win_c, win_p1_q, win_p2_q, win_p3_q, win_p4_q;
   logic [SW-1:0]        rsh_c, rsh_p1_q, rsh_p2_q, rsh_p3_q;
   logic [EXP_W-1:0]     exp_c;
   logic [MAN_W-1:0]     man_c;
   logic signed [EW-1:0] e_c;
   logic                 emax_c, ezero_c, shift_c;
   logic [INT_W-1:0]     mag_c;
   logic                 g_c, s_c, inc_c, inx_c;
   logic [INT_W:0]       sum_c, sum_p5_q;
   logic                 inx_p5_q, sign_p5_q, uns_p5_q, nan_p5_q, inf_p5_q, zer_p5_q, big_p5_q;
   logic [INT_W-1:0]     neg_c, dout_d, dout_q;
   logic                 ovf_d, inv_d, rdy_q, ovf_q, inv_q, inx_q;

`ifndef FP_FTOI_DIRECTED_RND_EN
   logic unused_rnd_hi;
   assign unused_rnd_hi = rnd_mode[1];
`endif

   // Stage 1: field decode, unbiased exponent, operand class, right-shift amount
   always_comb begin
      exp_c      = din[EXP_W+MAN_W-1:MAN_W];
      man_c      = din[MAN_W-1:0];
      e_c        = $signed(EW'(exp_c)) - BIAS_S;
      emax_c     = &exp_c;
      ezero_c    = ~|exp_c;
      ctl_c.sign = din[EXP_W+MAN_W];
`ifdef FP_FTOI_DIRECTED_RND_EN
      ctl_c.mode = rnd_mode;
`else
      ctl_c.mode = {1'b0, rnd_mode[0]};
`endif
      ctl_c.uns  = is_unsigned;
      ctl_c.mnz  = |man_c;
      ctl_c.nan  = emax_c & ctl_c.mnz;
      ctl_c.inf  = emax_c & ~ctl_c.mnz;
      ctl_c.zer  = ezero_c;
      ctl_c.big  = ~emax_c & ~ezero_c & (e_c >= INTW_S);
      ctl_c.tiny = ~emax_c & ~ezero_c & (e_c < NEG1_S);
      shift_c    = ~emax_c & ~ezero_c & ~ctl_c.big & ~ctl_c.tiny;
      // Leading one starts at the window MSB; shifting by INT_W-1-e aligns 2^0 to the integer LSB.
      win_c      = shift_c ? {1'b1, man_c, {(INT_W+1){1'b0}}} : {WIN{1'b0}};
      rsh_c      = RSH0 - e_c[SW-1:0];
   end

   // Stage 5: rounding increment and inexact
   always_comb begin
      mag_c = win_p4_q[WIN-1 -: INT_W];
      g_c   = win_p4_q[MAN_W+1];
      s_c   = (|win_p4_q[MAN_W:0]) | ctl_p4_q.tiny;
`ifdef FP_FTOI_DIRECTED_RND_EN
      inc_c = rnd_inc(ctl_p4_q.mode, ctl_p4_q.sign, g_c, s_c, mag_c[0]);
`else
      inc_c = rnd_inc(ctl_p4_q.mode, g_c, s_c, mag_c[0]);
`endif
      sum_c = {1'b0, mag_c} + {{INT_W{1'b0}}, inc_c};
      inx_c = ctl_p4_q.zer ? ctl_p4_q.mnz : (g_c | s_c);
   end

   // Stage 6: sign application, range check, saturation, special operands
   always_comb begin
      neg_c  = -sum_p5_q[INT_W-1:0];
      dout_d = sign_p5_q ? neg_c : sum_p5_q[INT_W-1:0];
      ovf_d  = 1'b0;
      inv_d  = 1'b0;
      if (nan_p5_q) begin
         inv_d  = 1'b1;
         dout_d = uns_p5_q ? {INT_W{1'b1}} : SMAX;
      end else if (inf_p5_q) begin
         inv_d  = 1'b1;
         ovf_d  = 1'b1;
         dout_d = sat_val(sign_p5_q, uns_p5_q);
      end else if (zer_p5_q) begin
         dout_d = {INT_W{1'b0}};
      end else begin
         if (uns_p5_q)
            ovf_d = sign_p5_q ? (|sum_p5_q) : sum_p5_q[INT_W];
         else if (sign_p5_q)
            ovf_d = sum_p5_q[INT_W] | (sum_p5_q[INT_W-1] & (|sum_p5_q[INT_W-2:0]));
         else
            ovf_d = sum_p5_q[INT_W] | sum_p5_q[INT_W-1];
         ovf_d = ovf_d | big_p5_q;
         if (ovf_d || (uns_p5_q && sign_p5_q)) dout_d = sat_val(sign_p5_q, uns_p5_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         vld_p3_q <= 1'b0;
         vld_p4_q <= 1'b0;
         vld_p5_q <= 1'b0;
         rdy_q    <= 1'b0;
         dout_q   <= {INT_W{1'b0}};
         ovf_q    <= 1'b0;
         inv_q    <= 1'b0;
         inx_q    <= 1'b0;
      end else begin
         vld_p1_q <= en;
         vld_p2_q <= vld_p1_q;
         vld_p3_q <= vld_p2_q;
         vld_p4_q <= vld_p3_q;
         vld_p5_q <= vld_p4_q;
         rdy_q    <= vld_p5_q;
         if (vld_p5_q) begin
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
            inv_q  <= inv_d;
            inx_q  <= inx_p5_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      ctl_p1_q  <= ctl_c;
      win_p1_q  <= win_c;
      rsh_p1_q  <= rsh_c;
      // Stages 2-4: barrel shift, one third of the shift-amount bits per stage
      ctl_p2_q  <= ctl_p1_q;
      win_p2_q  <= shr_grp(win_p1_q, rsh_p1_q, 0);
      rsh_p2_q  <= rsh_p1_q;
      ctl_p3_q  <= ctl_p2_q;
      win_p3_q  <= shr_grp(win_p2_q, rsh_p2_q, 1);
      rsh_p3_q  <= rsh_p2_q;
      ctl_p4_q  <= ctl_p3_q;
      win_p4_q  <= shr_grp(win_p3_q, rsh_p3_q, 2);
      sum_p5_q  <= sum_c;
      inx_p5_q  <= inx_c;
      sign_p5_q <= ctl_p4_q.sign;
      uns_p5_q  <= ctl_p4_q.uns;
      nan_p5_q  <= ctl_p4_q.nan;
      inf_p5_q  <= ctl_p4_q.inf;
      zer_p5_q  <= ctl_p4_q.zer;
      big_p5_q  <= ctl_p4_q.big;
   end

   assign dout       = dout_q;
   assign rdy        = rdy_q;
   assign overflow   = ovf_q;
   assign invalid_op = inv_q;
   assign inexact    = inx_q;

endmodule
